// File: rtl/control_sequencer.sv
// Microcoded-style control sequencer: six T-states of fetch/execute with a
// combinational control-word decode. Optional early retire via CTRL_EARLY_RETIRE_EN.
module control_sequencer (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] opcode,
  input  logic       run,
  input  logic       step,
  output logic       enPC,
  output logic       OE_PC,
  output logic       WE_MAR,
  output logic       OE_RAM,
  output logic       WE_IR,
  output logic       OE_IR,
  output logic       WE_Acc,
  output logic       OE_Acc,
  output logic       WE_Breg,
  output logic       OE_ALU,
  output logic       SUB,
  output logic       WE_OR,
  output logic       HLT,
  output logic [2:0] tstate,
  output logic       instr_done
);

  typedef enum logic [2:0] {
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4,
    T5 = 3'd5,
    T6 = 3'd6
  } tstate_e;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  tstate_e state_q, state_d;
  tstate_e last_t;
  tstate_e succ_t;
  logic    hlt_q, hlt_d;
  logic    advance;
  logic    active;

  // Final T-state of the current instruction; the wrap back to T1 follows it.
`ifdef CTRL_EARLY_RETIRE_EN
  always_comb begin
    case (opcode)
      OP_LDA:         last_t = T5;
      OP_ADD, OP_SUB: last_t = T6;
      OP_OUT:         last_t = T4;
      OP_HLT:         last_t = T6;
      default:        last_t = T3;
    endcase
  end
`else
  always_comb last_t = T6;
`endif

  always_comb begin
    case (state_q)
      T1:      succ_t = T2;
      T2:      succ_t = T3;
      T3:      succ_t = T4;
      T4:      succ_t = T5;
      T5:      succ_t = T6;
      default: succ_t = T1;
    endcase
  end

  // run and step are simply ORed: one advance per edge no matter which is high.
  assign advance = (run | step) & ~hlt_q;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    hlt_d   = hlt_q;
    if (advance) begin
      if (state_q == T4 && opcode == OP_HLT) begin
        hlt_d = 1'b1;
      end else if (state_q == last_t) begin
        state_d = T1;
      end else begin
        state_d = succ_t;
      end
    end
  end

  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (RESET) begin
      state_q <= T1;
      hlt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hlt_q   <= hlt_d;
    end
  end

  assign active = ~RESET & ~hlt_q;

  always_comb begin
    enPC    = 1'b0;
    OE_PC   = 1'b0;
    WE_MAR  = 1'b0;
    OE_RAM  = 1'b0;
    WE_IR   = 1'b0;
    OE_IR   = 1'b0;
    WE_Acc  = 1'b0;
    OE_Acc  = 1'b0;
    WE_Breg = 1'b0;
    OE_ALU  = 1'b0;
    SUB     = 1'b0;
    WE_OR   = 1'b0;
    if (active) begin
      case (state_q)
        T1: begin
          OE_PC  = 1'b1;
          WE_MAR = 1'b1;
        end
        T2: enPC = 1'b1;
        T3: begin
          OE_RAM = 1'b1;
          WE_IR  = 1'b1;
        end
        T4: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB: begin
              OE_IR  = 1'b1;
              WE_MAR = 1'b1;
            end
            OP_OUT: begin
              OE_Acc = 1'b1;
              WE_OR  = 1'b1;
            end
            default: ;
          endcase
        end
        T5: begin
          case (opcode)
            OP_LDA: begin
              OE_RAM = 1'b1;
              WE_Acc = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              OE_RAM  = 1'b1;
              WE_Breg = 1'b1;
            end
            default: ;
          endcase
        end
        T6: begin
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            OE_ALU = 1'b1;
            WE_Acc = 1'b1;
            SUB    = (opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

  assign instr_done = active & (state_q == last_t);
  assign HLT        = hlt_q;
  assign tstate     = state_q;

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 SHALL have ports, one per line, as follows:
- CLK  in  1  system clock, all state changes on rising edge
- RESET  in  1  synchronous active-high reset
- opcode  in  4  instruction register upper nibble, valid from T4
- run  in  1  level: free-run T-states
- step  in  1  single-cycle pulse: advance one T-state when run=0 (debounced upstream)
- enPC  out  1  PC increment (Cp)
- OE_PC  out  1  PC drives bus (Ep)
- WE_MAR  out  1  MAR loads from bus (Lm)
- OE_RAM  out  1  RAM drives bus (CE)
- WE_IR  out  1  IR loads from bus (Li)
- OE_IR  out  1  IR low nibble drives bus (Ei)
- WE_Acc  out  1  accumulator loads from bus (La)
- OE_Acc  out  1  accumulator drives bus (Ea)
- WE_Breg  out  1  B register loads from bus (Lb)
- OE_ALU  out  1  ALU drives bus (Eu)
- SUB  out  1  ALU subtract select (Su)
- WE_OR  out  1  output register loads from bus (Lo)
- HLT  out  1  halted flag
- tstate  out  3  current T-state, 1..6 (binary)
- instr_done  out  1  high during the final T-state of the current instruction

Function
REQ-003 SHALL hold a T-state register cycling T1->T2->...->T6->T1; advance on a CLK edge iff (run | step) & ~HLT & ~RESET.
REQ-004 run=1 and step=1 together: run dominates; exactly one advance per edge, no extra step.
REQ-005 run=0, step=0: T-state and all outputs held unchanged.
REQ-006 Control outputs SHALL be combinational decode of (tstate, opcode); zero latency from state change.
REQ-007 Fetch, opcode-independent: T1 OE_PC,WE_MAR; T2 enPC; T3 OE_RAM,WE_IR.
REQ-008 LDA 4'b0000: T4 OE_IR,WE_MAR; T5 OE_RAM,WE_Acc; T6 none.
REQ-009 ADD 4'b0001: T4 OE_IR,WE_MAR; T5 OE_RAM,WE_Breg; T6 OE_ALU,WE_Acc.
REQ-010 SUB 4'b0010: as ADD, plus SUB=1 in T6 only.
REQ-011 OUT 4'b1110: T4 OE_Acc,WE_OR; T5-T6 none.
REQ-012 HLT 4'b1111: on the edge ending T4 set HLT=1; HLT sticky until RESET; while HLT=1 all control outputs=0, tstate frozen at T4.
REQ-013 Any other opcode: NOP, no control asserted T4-T6.
REQ-014 At most one OE_* output high in any cycle; violation is a design error.
REQ-015 instr_done high in T6 (or the last active state per REQ-019); never while HLT=1.

Reset
REQ-016 RESET=1 at a CLK edge: tstate=T1, HLT=0, regardless of current state, run or step.
REQ-017 While RESET=1, all control outputs and instr_done SHALL be forced 0; T1 decode appears the first cycle after release.
REQ-018 RESET mid-instruction abandons the instruction; no partial completion.

Configuration
REQ-019 Macro CTRL_EARLY_RETIRE_EN defined: after the last non-idle T-state, return to T1 (LDA after T5, OUT after T4, NOP after T3, ADD/SUB after T6); instr_done marks that state. Undefined: every instruction takes six T-states.

Verification
REQ-020 RESET, run=1, opcode=0000: T1..T6 show Ep+Lm, Cp, CE+Li, Ei+Lm, CE+La, none; then T1 again.
REQ-021 run=1, opcode=0010: T6 asserts OE_ALU, WE_Acc, SUB=1; SUB=0 in every other T-state.
REQ-022 opcode=1111, run=1: HLT=1 after T4, all controls 0 for 20 further cycles; RESET clears HLT, tstate=1.
REQ-023 run=0, three step pulses spaced 5 cycles: tstate 1->2->3->4, constant between pulses; run=1 with step=1 advances exactly one state.
REQ-024 RESET asserted during T5 of ADD: next cycle tstate=1, WE_Breg never asserted.
REQ-025 With CTRL_EARLY_RETIRE_EN: opcode=1110 loops T1-T4 (period 4); without: period 6; one-OE rule checked every cycle throughout.
